counter_updown_timer: RTL

Parametrised up/down timer-counter that succeeds the plain n-bit loadable counter. It adds runtime direction, a programmable terminal limit, a clock prescaler, three terminal-count modes (wrap, saturate, one-shot) and a start/stop state machine. It serves as the general-purpose event/interval counter for control blocks that need periodic or single terminal-count pulses.

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_updown_timer_tick_prescaler.sv | 38 +++
 rtl/counter_updown_timer.sv | 94 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types for the up/down timer-counter: terminal-count modes and control states.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP,
    MODE_SAT,
    MODE_ONESHOT,
    MODE_RSVD
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/counter_updown_timer_tick_prescaler.sv
// Clock divider for the timer: tick is combinational from the divider register,
// so a tick qualifies the count update on the same edge.
module tick_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  // >= rather than == so a divisor lowered mid-run below pre_cnt still ticks promptly
  assign tick = en && (pre_cnt_q >= prescale);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (tick) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/counter_updown_timer.sv
// Up/down timer-counter with programmable limit, prescaler and wrap/saturate/one-shot
// terminal modes; per-cycle priority is load > stop > start > tick, all outputs registered.
module counter_updown_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             running,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             running_q, done_q;
  logic             pre_clr;
  logic             tick;
  logic             terminal;

  tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q == ST_RUN),
    .clr      (pre_clr),
    .prescale (prescale),
    .tick     (tick)
  );

  assign terminal = dir ? (count_q >= limit) : (count_q == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    pre_clr = 1'b0;
    if (load) begin
      count_d = load_data;
      pre_clr = 1'b1;
      if (state_q == ST_DONE) state_d = ST_IDLE;
    end else if (stop) begin
      pre_clr = 1'b1;
      if (state_q == ST_RUN) state_d = ST_IDLE;
    end else if (start && (state_q != ST_RUN)) begin
      state_d = ST_RUN;
      pre_clr = 1'b1;
    end else if ((state_q == ST_RUN) && tick) begin
      if (!terminal) begin
        count_d = dir ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
      end else begin
        tc_d = 1'b1;
        case (mode_e'(mode))
          MODE_SAT:     count_d = count_q;
          MODE_ONESHOT: state_d = ST_DONE;
          default:      count_d = dir ? '0 : limit;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tc_q      <= tc_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign running = running_q;
  assign done    = done_q;

endmodule
